// File: rtl/div_pkg.sv
// div_pkg: shared types and sizing for the sequential restoring divider
package div_pkg;
    localparam int DIV_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring iteration (shift {r,q} left, trial subtract d)
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_sh;
    // r[WIDTH] is always 0 between steps because r < d, so dropping it in the shift is safe
    always_comb begin
        r_sh   = {r[WIDTH-1:0], q[WIDTH-1]};
        q_sh   = {q[WIDTH-2:0], 1'b0};
        trial  = r_sh - {1'b0, d};
        r_next = trial[WIDTH] ? r_sh : trial;
        q_next = trial[WIDTH] ? q_sh : (q_sh | WIDTH'(1));
    end
endmodule

// File: rtl/seq_divider_8bit.sv
// seq_divider_8bit: multi-cycle unsigned restoring divider, one step per clock
module seq_divider_8bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = cnt_width(WIDTH);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   r_q, r_d, r_next;
    logic [WIDTH-1:0] q_q, q_d, q_next;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             accept;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .q      (q_q),
        .d      (d_q),
        .r_next (r_next),
        .q_next (q_next)
    );

    // Next-state: accept from IDLE/DONE, iterate in RUN, publish results on the last step
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        accept      = start && (state_q != RUN);
        if (accept) begin
            q_d   = dividend;
            d_d   = divisor;
            r_d   = '0;
            cnt_d = '0;
            if (divisor == '0) begin
                state_d     = DONE;
                quotient_d  = '1;
                remainder_d = dividend;
                dbz_d       = 1'b1;
            end else begin
                state_d = RUN;
                dbz_d   = 1'b0;
            end
        end else if (state_q == RUN) begin
            r_d   = r_next;
            q_d   = q_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d     = DONE;
                quotient_d  = q_next;
                remainder_d = r_next[WIDTH-1:0];
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
endmodule
